// File: rtl/spi_master.sv
// spi_master: 16-bit SPI master, SPI_CLK idles low, MOSI launched on rising and MISO sampled on falling SPI_CLK edges.
// Build option: define SPI_MASTER_LOOPBACK_EN to receive the internal MOSI stream instead of the MISO port.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST_N,
    input  logic [15:0] TX_DATA,
    input  logic        TX_VALID,
    output logic        TX_READY,
    output logic [15:0] RX_DATA,
    output logic        RX_VALID,
    output logic        BUSY,
    output logic        SPI_CLK,
    output logic        SSEL,
    output logic        MOSI,
    input  logic        MISO
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    localparam logic [7:0] LP_RELOAD = 8'(CLK_DIV - 1);
    state_t      r_state;
    logic        r_armed;
    logic [7:0]  r_cnt;
    logic [4:0]  r_bit;
    logic [15:0] r_tx;
    logic [15:0] r_rx;
    logic [15:0] r_rx_data;
    logic        r_rx_valid;
    logic        r_sclk;
    logic        r_ssel;
    logic        r_mosi;
    logic        w_tick;
    logic        w_ready;
    logic        w_sdi;
    assign w_tick  = r_cnt == 8'd0;
    // r_armed keeps TX_READY low while reset is held, even though the state is already IDLE
    assign w_ready = r_armed && (r_state == IDLE);
`ifdef SPI_MASTER_LOOPBACK_EN
    logic w_unused_miso;
    assign w_unused_miso = MISO;
    assign w_sdi = r_mosi;
`else
    assign w_sdi = MISO;
`endif
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            r_state    <= IDLE;
            r_armed    <= 1'b0;
            r_cnt      <= 8'd0;
            r_bit      <= 5'd0;
            r_tx       <= 16'h0000;
            r_rx       <= 16'h0000;
            r_rx_data  <= 16'h0000;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
            r_ssel     <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_armed    <= 1'b1;
            r_rx_valid <= 1'b0;
            if (r_state != IDLE) r_cnt <= w_tick ? LP_RELOAD : r_cnt - 8'd1;
            case (r_state)
                IDLE: if (TX_VALID && w_ready) begin
                    r_tx    <= TX_DATA;
                    r_ssel  <= 1'b0;
                    r_cnt   <= LP_RELOAD;
                    r_state <= SETUP;
                end
                SETUP: if (w_tick) begin
                    r_bit   <= 5'd0;
                    r_state <= SHIFT;
                end
                // each tick is one half-period: launch on the rising half, capture on the falling half
                SHIFT: if (w_tick) begin
                    r_sclk <= ~r_sclk;
                    r_bit  <= r_bit + 5'd1;
                    if (!r_sclk) begin
                        r_mosi <= r_tx[15];
                        r_tx   <= {r_tx[14:0], 1'b0};
                    end else begin
                        r_rx <= {r_rx[14:0], w_sdi};
                    end
                    if (r_bit == 5'd31) r_state <= HOLD;
                end
                HOLD: if (w_tick) begin
                    r_ssel     <= 1'b1;
                    r_mosi     <= 1'b0;
                    r_rx_data  <= r_rx;
                    r_rx_valid <= 1'b1;
                    r_state    <= GAP;
                end
                GAP: if (w_tick) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign TX_READY = w_ready;
    assign BUSY     = r_state != IDLE;
    assign RX_DATA  = r_rx_data;
    assign RX_VALID = r_rx_valid;
    assign SPI_CLK  = r_sclk;
    assign SSEL     = r_ssel;
    assign MOSI     = r_mosi;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: table-driven vectors with a scoreboard, a bit-level SPI slave model, and corner-case sequences.
module tb_spi_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] tx_data = 16'h0000;
    logic        tx_valid = 1'b0;
    logic        tx_valid_s = 1'b0;
    logic        miso = 1'b0;
    logic [15:0] drv_slv = 16'h0000;
    logic        tx_ready, rx_valid, busy, sclk, ssel, mosi;
    logic [15:0] rx_data;
    logic        tx_ready_s, rx_valid_s, busy_s, sclk_s, ssel_s, mosi_s;
    logic [15:0] rx_data_s;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(4)) u_dut (
        .SYS_CLK(clk), .SYS_RST_N(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid),
        .TX_READY(tx_ready), .RX_DATA(rx_data), .RX_VALID(rx_valid), .BUSY(busy),
        .SPI_CLK(sclk), .SSEL(ssel), .MOSI(mosi), .MISO(miso)
    );

    spi_master #(.CLK_DIV(255)) u_slow (
        .SYS_CLK(clk), .SYS_RST_N(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid_s),
        .TX_READY(tx_ready_s), .RX_DATA(rx_data_s), .RX_VALID(rx_valid_s), .BUSY(busy_s),
        .SPI_CLK(sclk_s), .SSEL(ssel_s), .MOSI(mosi_s), .MISO(1'b0)
    );

    typedef struct {
        logic [15:0] tx;
        logic [15:0] rx;
    } exp_t;
    typedef struct {
        logic [15:0] tx;
        logic [15:0] slv;
    } vec_t;

    exp_t        exp_q[$];
    logic [15:0] slv_q[$];
    int n_vec = 0, n_fail = 0;
    int cyc = 0, rx_count = 0, rises = 0, k = 0, gap_cnt = 0, acc_n = 0, last_acc = 0;
    int rises_s = 0, ph = 0;
    bit bb = 1'b0;
    logic        sclk_p = 1'b0, ssel_p = 1'b1, sclk_sp = 1'b0;
    logic [15:0] slv = 16'h0000, mosi_cap = 16'h0000;

    function automatic logic [15:0] exp_rx(input logic [15:0] tx, input logic [15:0] s);
`ifdef SPI_MASTER_LOOPBACK_EN
        return tx;
`else
        return s;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // scoreboard, slave model and protocol monitor for the CLK_DIV=4 instance
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            slv_q.delete();
            miso = 1'b0;
        end else begin
            if (tx_valid && tx_ready) begin
                exp_q.push_back('{tx: tx_data, rx: exp_rx(tx_data, drv_slv)});
                slv_q.push_back(drv_slv);
                if (bb && acc_n > 0) begin
                    check("accept_spacing", cyc - last_acc, 141);
                    check("ssel_high_gap", gap_cnt, 4);
                end
                last_acc = cyc;
                gap_cnt = 0;
                acc_n++;
            end
            if (ssel && busy) begin
                gap_cnt++;
                check("mosi_in_gap", {31'd0, mosi}, 0);
            end
            if (ssel_p && !ssel) begin
                slv = (slv_q.size() > 0) ? slv_q.pop_front() : 16'h0000;
                k = 0;
                rises = 0;
                mosi_cap = 16'h0000;
            end
            if (!sclk_p && sclk) begin
                if (k < 16) miso = slv[15-k];
                k++;
                rises++;
            end
            if (sclk_p && !sclk) mosi_cap = {mosi_cap[14:0], mosi};
            if (rx_valid) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got RX_VALID with data %0h, expected none", rx_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rx_data", {16'd0, rx_data}, {16'd0, e.rx});
                    check("mosi_word", {16'd0, mosi_cap}, {16'd0, e.tx});
                    check("rise_count", rises, 16);
                    check("ssel_at_rx", {31'd0, ssel}, 1);
                end
            end
        end
        sclk_p = sclk;
        ssel_p = ssel;
    end

    // SPI_CLK phase lengths of the CLK_DIV=255 instance; the first low phase includes SETUP
    always @(negedge clk) begin
        if (sclk_s != sclk_sp) begin
            if (sclk_s) begin
                if (rises_s > 0) check("slow_low_phase", ph, 255);
                rises_s++;
            end else begin
                check("slow_high_phase", ph, 255);
            end
            ph = 1;
        end else begin
            ph++;
        end
        sclk_sp = sclk_s;
    end

    task automatic send(input logic [15:0] tx, input logic [15:0] s);
        int t = 0;
        tx_data = tx;
        drv_slv = s;
        tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: got TX_READY=0, expected 1 within 400 cycles");
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int target);
        int t = 0;
        while (rx_count < target && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("rx_pulse_count", rx_count, target);
    endtask

    initial begin
        vec_t vt[7];
        int base, t, acc;
        vt[0] = '{tx: 16'hA5C3, slv: 16'h1234};
        vt[1] = '{tx: 16'hFFFF, slv: 16'h0000};
        vt[2] = '{tx: 16'h0000, slv: 16'hFFFF};
        vt[3] = '{tx: 16'h8001, slv: 16'h7FFE};
        vt[4] = '{tx: 16'h5A5A, slv: 16'hA5A5};
        vt[5] = '{tx: 16'h0001, slv: 16'h8000};
        vt[6] = '{tx: 16'h3C96, slv: 16'hC369};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_ready", {31'd0, tx_ready}, 0);
        check("rst_ssel", {31'd0, ssel}, 1);
        check("rst_sclk", {31'd0, sclk}, 0);
        check("rst_mosi", {31'd0, mosi}, 0);
        check("rst_rx_data", {16'd0, rx_data}, 0);
        check("rst_rx_valid", {31'd0, rx_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_slow_ssel", {31'd0, ssel_s}, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, tx_ready}, 1);

        for (int i = 0; i < 7; i++) begin
            base = rx_count;
            send(vt[i].tx, vt[i].slv);
            wait_rx(base + 1);
        end

        // back-to-back: TX_VALID stays high across three words
        base = rx_count;
        bb = 1'b1;
        tx_data = 16'h1111;
        drv_slv = 16'hEEEE;
        tx_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            t = 0;
            @(negedge clk);
            while (!tx_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            check("bb_ready", {31'd0, tx_ready}, 1);
            @(posedge clk);
            #1;
            if (j == 0) begin tx_data = 16'h2222; drv_slv = 16'hDDDD; end
            else if (j == 1) begin tx_data = 16'h4444; drv_slv = 16'hBBBB; end
            else tx_valid = 1'b0;
        end
        wait_rx(base + 3);
        bb = 1'b0;

        // reset after the 7th SPI_CLK rising edge
        tx_data = 16'h6B2D;
        drv_slv = 16'h9F01;
        tx_valid = 1'b1;
        t = 0;
        while ((rises != 7 || ssel) && t < 400) begin
            @(negedge clk);
            t++;
            if (!tx_ready) tx_valid = 1'b0;
        end
        check("abort_reached_rise7", rises, 7);
        base = rx_count;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ssel", {31'd0, ssel}, 1);
        check("abort_sclk", {31'd0, sclk}, 0);
        check("abort_mosi", {31'd0, mosi}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_tx_ready", {31'd0, tx_ready}, 0);
        check("abort_rx_data", {16'd0, rx_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after", {31'd0, tx_ready}, 1);
        repeat (200) @(negedge clk);
        check("abort_no_rx_valid", rx_count, base);
        send(16'hC0DE, 16'h0BAD);
        wait_rx(base + 1);

        // CLK_DIV=255 single word
        rises_s = 0;
        tx_valid_s = 1'b1;
        tx_data = 16'hC3A5;
        @(negedge clk);
        check("slow_ready", {31'd0, tx_ready_s}, 1);
        acc = cyc;
        @(posedge clk);
        #1 tx_valid_s = 1'b0;
        t = 0;
        @(negedge clk);
        while (!tx_ready_s && t < 10000) begin
            @(negedge clk);
            t++;
        end
        check("slow_txn_cycles", cyc - acc, 1 + 35 * 255);
        check("slow_rises", rises_s, 16);
        check("slow_rx_data", {16'd0, rx_data_s}, {16'd0, exp_rx(16'hC3A5, 16'h0000)});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
